// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte-stream requesters.
// An owner keeps the transmitter until its last byte, or until it stalls for TIMEOUT cycles.
module uart_tx_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic [CNT_W-1:0]  bytes_sent,
    output logic              timeout_rel
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [TMR_W-1:0] timer;
    logic             last_r;

    logic [NREQ-1:0]  rot;
    logic [NREQ-1:0]  winner_oh;
    logic             found;
    int               sum;
    int               wsel;
    int               owner_i;
    logic             owner_valid;
    logic             owner_last;
    logic [7:0]       owner_data;
    logic [PTR_W-1:0] next_ptr;

    // Rotating the request vector by rr_ptr turns the round-robin scan into a plain first-one search.
    always_comb begin
        rot   = NREQ'({req_valid, req_valid} >> rr_ptr);
        found = 1'b0;
        sum   = 0;
        wsel  = 0;
        for (int j = 0; j < NREQ; j++) begin
            sum = int'(rr_ptr) + j;
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            if (!found && rot[j]) begin
                found = 1'b1;
                wsel  = sum;
            end
        end
        winner_oh = '0;
        for (int n = 0; n < NREQ; n++) begin
            winner_oh[n] = found && (n == wsel);
        end
    end

    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        owner_i     = 0;
        for (int j = 0; j < NREQ; j++) begin
            if (grant[j]) begin
                owner_valid = req_valid[j];
                owner_last  = req_last[j];
                owner_data  = req_data[8*j +: 8];
                owner_i     = j;
            end
        end
        next_ptr = PTR_W'((owner_i + 1) % NREQ);
    end

    assign req_ready = (state == LOAD) ? grant : '0;

    // The timer counts idle LOAD cycles; release fires on the cycle the count would reach TIMEOUT.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            timer       <= '0;
            last_r      <= 1'b0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            bytes_sent  <= '0;
            timeout_rel <= 1'b0;
        end else begin
            tx_start    <= 1'b0;
            timeout_rel <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant <= winner_oh;
                        timer <= '0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (owner_valid) begin
                        tx_data  <= owner_data;
                        last_r   <= owner_last;
                        tx_start <= 1'b1;
                        state    <= START;
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        grant       <= '0;
                        rr_ptr      <= next_ptr;
                        timer       <= '0;
                        timeout_rel <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                START: begin
                    bytes_sent <= bytes_sent + CNT_W'(1);
                    state      <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (last_r) begin
                            grant  <= '0;
                            rr_ptr <= next_ptr;
                            state  <= IDLE;
                        end else begin
                            timer <= '0;
                            state <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
